mux3_bus_arbiter: RTL and testbench
===================================

// Module: mux3_bus_arbiter
// PURPOSE
// - Round-robin arbiter that shares the 4-bit 3:1 output mux among three requesters (A, B, C).
// - Drives the mux select from registered grant state and presents the selected data with a valid flag.
// - Sits between three producer units and one shared 4-bit bus.
// - Enforces fairness with a bounded hold time when other requesters are waiting.
// PARAMETERS
// - MAX_HOLD  8  cycles an owner may keep the bus while another request is pending (>=2)
// - CNT_W     4  hold counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
// - clk       in   1  single clock; all state updates on posedge
// - reset_n   in   1  asynchronous, active-low reset
// - req       in   3  request per requester; bit0=A, bit1=B, bit2=C; level, held while owning
// - data_a    in   4  requester A data
// - data_b    in   4  requester B data
// - data_c    in   4  requester C data
// - gnt       out  3  one-hot grant, registered; 000 = bus idle
// - sel       out  2  mux select, registered; 00=A 01=B 10=C; 11 never driven
// - bus_out   out  4  selected data, combinational from the mux, driven by registered sel
// - bus_valid out  1  = |gnt
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, gnt=000, sel=00, bus_valid=0, hold_cnt=0, last=C.
//   last=C gives A first priority after reset.
// - bus_out during reset/idle follows the mux with sel=00, i.e. data_a; consumers qualify with bus_valid.
// - Round-robin order: search starts at last+1 and wraps C->A; last is updated to each new owner.
// - States: IDLE, GRANT.
// - IDLE, req==000: stay in IDLE.
// - IDLE, req!=000: pick winner by RR; next edge gnt=onehot(winner), sel=winner, ->GRANT.
//   Latency is 1 cycle from sampled req to gnt.
// - GRANT, owner req=1, no other req: keep grant indefinitely; hold_cnt stays 0.
// - GRANT, owner req=1, other req pending: hold_cnt increments each cycle.
//   When hold_cnt==MAX_HOLD-1, the next edge passes the grant to the RR winner among the others
//   and clears hold_cnt (preemption).
// - GRANT, owner req=0 (release):
//   - other req pending: next edge grants the RR winner directly (no idle cycle) and clears hold_cnt.
//   - no other req: ->IDLE, gnt=000, hold_cnt=0.
// - Release and preemption on the same cycle: treat as release; the outcome is identical.
// - Grant is decided only from req sampled at the edge. A req pulsed and dropped between edges is never granted.
// - A released owner that re-asserts req gets lowest RR priority relative to the other waiting requesters.
// - gnt is always one-hot or zero; sel always equals the index of the set gnt bit (00 when idle).
// - Reset asserted mid-grant: all outputs clear without a clock edge; arbitration restarts from IDLE.
// - hold_cnt saturates logically at MAX_HOLD-1, never wraps; it resets on every ownership change.
// STRUCTURE
// - Shared include mux_arb_defs.vh holds:
//   - SEL_A=2'd0, SEL_B=2'd1, SEL_C=2'd2
//   - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
// - Instantiate the existing 3:1 4-bit mux (a=data_a, b=data_b, c=data_c, sel=sel) for bus_out.
// - Arbitration FSM, RR pointer and hold counter live in this module.
// - Optional sub-module rr_pick3: combinational RR winner from (req mask, last) -> winner index + any flag.
// TESTING
// - Reset: req=111 held through reset -> gnt=000, sel=00, bus_valid=0.
//   First edge after reset_n rises -> gnt=001, sel=00.
// - RR: req=111, each owner drops req 2 cycles after its grant, then re-asserts.
//   -> grant order A,B,C,A with no idle cycle between owners.
// - Preempt (MAX_HOLD=8): A owns and holds; B asserts at cycle t.
//   -> gnt=010 at edge t+8; A is re-granted only after B releases.
// - Lone owner: only req[2] held 50 cycles -> gnt=100 and sel=10 throughout, no revocation.
// - Datapath: B granted, data_b=4'hA, data_a/data_c toggling -> bus_out=4'hA, bus_valid=1 every cycle.
// - Async reset mid-grant (gnt=100) -> gnt=000, sel=00 immediately, before any clock edge.

Source files
------------

// File: rtl/mux3_bus_arbiter_pkg.sv
// Shared definitions for the three-way round-robin bus arbiter: select codes,
// FSM encoding and the 4-bit 3:1 data mux.
package mux3_bus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // Select code 11 is never produced; it falls back to A like idle.
  function automatic logic [3:0] mux3(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c, input logic [1:0] s);
    case (s)
      SEL_B:   return b;
      SEL_C:   return c;
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/mux3_bus_arbiter_rr_pick3.sv
// Combinational round-robin pick among three requesters: the search starts at
// the requester after 'last' and wraps C->A.
module mux3_bus_arbiter_rr_pick3
  import mux3_bus_arbiter_pkg::*;
(
  input  logic [2:0] mask,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       any
);

  logic [1:0] first, second, third;

  always_comb begin
    first  = SEL_A;
    second = SEL_B;
    third  = SEL_C;
    case (last)
      SEL_A: begin first = SEL_B; second = SEL_C; third = SEL_A; end
      SEL_B: begin first = SEL_C; second = SEL_A; third = SEL_B; end
      default: begin first = SEL_A; second = SEL_B; third = SEL_C; end
    endcase
  end

  always_comb begin
    any    = |mask;
    winner = SEL_A;
    if (mask[first])       winner = first;
    else if (mask[second]) winner = second;
    else if (mask[third])  winner = third;
  end

endmodule

// File: rtl/mux3_bus_arbiter.sv
// Round-robin arbiter sharing one 4-bit bus among three producers, with a
// bounded hold time whenever another requester is waiting.
module mux3_bus_arbiter
  import mux3_bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] req,
  input  logic [3:0] data_a,
  input  logic [3:0] data_b,
  input  logic [3:0] data_c,
  output logic [2:0] gnt,
  output logic [1:0] sel,
  output logic [3:0] bus_out,
  output logic       bus_valid,
  output state_t     dbg_state
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [2:0]       gnt_d;
  logic [1:0]       sel_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [1:0]       last_q, last_d;
  logic [2:0]       pick_mask;
  logic [1:0]       winner;
  logic             pick_any;
  logic             owner_req;
  logic             take;

  // While granted, only the other requesters compete; gnt is one-hot so it masks the owner.
  assign pick_mask = (state_q == ST_GRANT) ? (req & ~gnt) : req;
  assign owner_req = |(req & gnt);

  mux3_bus_arbiter_rr_pick3 u_pick (
    .mask   (pick_mask),
    .last   (last_q),
    .winner (winner),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = sel;
    hold_d  = hold_q;
    last_d  = last_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) take = 1'b1;
      end
      ST_GRANT: begin
        if (!owner_req) begin
          if (pick_any) begin
            take = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 3'b000;
            sel_d   = SEL_A;
            hold_d  = '0;
          end
        end else if (pick_any) begin
          if (hold_q == HOLD_LAST) take = 1'b1;
          else                     hold_d = hold_q + 1'b1;
        end else begin
          hold_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Any ownership change lands here, so last and hold_cnt stay consistent.
    if (take) begin
      state_d = ST_GRANT;
      gnt_d   = onehot3(winner);
      sel_d   = winner;
      last_d  = winner;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gnt     <= 3'b000;
      sel     <= SEL_A;
      hold_q  <= '0;
      last_q  <= SEL_C;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign bus_out   = mux3(data_a, data_b, data_c, sel);
  assign bus_valid = |gnt;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux3_bus_arbiter.sv
// Self-checking bench for mux3_bus_arbiter: vector table, hand-written corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_mux3_bus_arbiter;
  import mux3_bus_arbiter_pkg::*;

  localparam int MAX_HOLD = 8;
  localparam int W = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [3:0] data_a = 4'h1, data_b = 4'h2, data_c = 4'h3;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic [3:0] bus_out;
  logic       bus_valid;
  state_t     dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  int m_owner, m_last, m_wait;

  typedef struct {
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] sel;
  } vec_t;
  vec_t tbl[14];

  always #5 clk = ~clk;

  mux3_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .data_a    (data_a),
    .data_b    (data_b),
    .data_c    (data_c),
    .gnt       (gnt),
    .sel       (sel),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .dbg_state (dbg_state)
  );

  function automatic logic [W-1:0] pack(input logic [2:0] g, input logic [1:0] s,
                                        input logic v, input logic [3:0] b);
    return {g, s, v, b};
  endfunction

  task automatic check(input string name, input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = {gnt, sel, bus_valid, bus_out};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got gnt=%b sel=%b valid=%b bus=%h, want gnt=%b sel=%b valid=%b bus=%h",
               name, $time, act[9:7], act[6:5], act[4], act[3:0],
               exp[9:7], exp[6:5], exp[4], exp[3:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Reference model: owner index (-1 = idle), last owner, cycles held with others waiting.
  task automatic model_reset();
    m_owner = -1;
    m_last  = 2;
    m_wait  = 0;
  endtask

  function automatic int rr_pick(input logic [2:0] mask, input int last);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [2:0] r);
    logic [2:0] others;
    others = r;
    if (m_owner >= 0) others[m_owner] = 1'b0;
    if (m_owner < 0) begin
      if (r != 3'b000) begin
        m_owner = rr_pick(r, m_last);
        m_last  = m_owner;
        m_wait  = 0;
      end
    end else if (!r[m_owner]) begin
      if (others != 3'b000) begin
        m_owner = rr_pick(others, m_last);
        m_last  = m_owner;
      end else begin
        m_owner = -1;
      end
      m_wait = 0;
    end else if (others != 3'b000) begin
      m_wait++;
      if (m_wait == MAX_HOLD) begin
        m_owner = rr_pick(others, m_last);
        m_last  = m_owner;
        m_wait  = 0;
      end
    end else begin
      m_wait = 0;
    end
  endtask

  function automatic logic [W-1:0] model_out(input logic [3:0] da, input logic [3:0] db,
                                             input logic [3:0] dc);
    if (m_owner < 0) return pack(3'b000, 2'd0, 1'b0, da);
    return pack(3'(3'b001 << m_owner), 2'(m_owner), 1'b1,
                (m_owner == 1) ? db : (m_owner == 2) ? dc : da);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] eb;

    tbl[0]  = '{3'b111, 3'b001, 2'd0};
    tbl[1]  = '{3'b111, 3'b001, 2'd0};
    tbl[2]  = '{3'b110, 3'b010, 2'd1};
    tbl[3]  = '{3'b111, 3'b010, 2'd1};
    tbl[4]  = '{3'b101, 3'b100, 2'd2};
    tbl[5]  = '{3'b111, 3'b100, 2'd2};
    tbl[6]  = '{3'b011, 3'b001, 2'd0};
    tbl[7]  = '{3'b000, 3'b000, 2'd0};
    tbl[8]  = '{3'b000, 3'b000, 2'd0};
    tbl[9]  = '{3'b010, 3'b010, 2'd1};
    tbl[10] = '{3'b001, 3'b001, 2'd0};
    tbl[11] = '{3'b100, 3'b100, 2'd2};
    tbl[12] = '{3'b100, 3'b100, 2'd2};
    tbl[13] = '{3'b000, 3'b000, 2'd0};

    // Requests held high through reset
    req = 3'b111;
    reset_n = 1'b0;
    repeat (3) tick();
    check("reset_hold", pack(3'b000, 2'd0, 1'b0, 4'h1));
    reset_n = 1'b1;
    tick();
    check("first_grant", pack(3'b001, 2'd0, 1'b1, 4'h1));

    // Vector table: round-robin order A,B,C,A then idle/regrant cases
    req = 3'b000;
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req;
      tick();
      eb = (tbl[i].gnt == 3'b000) ? 4'h1 : 4'({2'b00, tbl[i].sel} + 4'd1);
      check($sformatf("tbl[%0d]", i), pack(tbl[i].gnt, tbl[i].sel, |tbl[i].gnt, eb));
    end

    // Request pulsed and dropped between edges
    apply_reset();
    #2 req = 3'b010;
    #3 req = 3'b000;
    tick();
    check("pulse_ignored", pack(3'b000, 2'd0, 1'b0, 4'h1));

    // Preemption: A owns, B starts waiting, switch on the 8th edge
    req = 3'b001;
    tick();
    check("preempt_a_grant", pack(3'b001, 2'd0, 1'b1, 4'h1));
    repeat (2) tick();
    req = 3'b011;
    for (int k = 1; k <= MAX_HOLD; k++) begin
      tick();
      if (k < MAX_HOLD) check($sformatf("preempt_hold_%0d", k), pack(3'b001, 2'd0, 1'b1, 4'h1));
      else              check("preempt_switch", pack(3'b010, 2'd1, 1'b1, 4'h2));
    end
    repeat (2) begin
      tick();
      check("preempt_b_keeps", pack(3'b010, 2'd1, 1'b1, 4'h2));
    end
    req = 3'b001;
    tick();
    check("preempt_a_regrant", pack(3'b001, 2'd0, 1'b1, 4'h1));

    // Lone owner C for 50 cycles
    req = 3'b000;
    apply_reset();
    req = 3'b100;
    repeat (50) begin
      tick();
      check("lone_c", pack(3'b100, 2'd2, 1'b1, 4'h3));
    end

    // Datapath: B owns, other data toggling
    req = 3'b010;
    tick();
    data_b = 4'hA;
    for (int k = 0; k < 10; k++) begin
      data_a = 4'($urandom_range(0, 15));
      data_c = 4'($urandom_range(0, 15));
      #1;
      check("datapath_b", pack(3'b010, 2'd1, 1'b1, 4'hA));
      tick();
    end

    // Async reset while C owns
    req = 3'b100;
    tick();
    check("c_owner", pack(3'b100, 2'd2, 1'b1, data_c));
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", pack(3'b000, 2'd0, 1'b0, data_a));
    tick();
    reset_n = 1'b1;

    // Randomized traffic against the reference model
    req = 3'b000;
    apply_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      data_a = 4'($urandom_range(0, 15));
      data_b = 4'($urandom_range(0, 15));
      data_c = 4'($urandom_range(0, 15));
      model_edge(req);
      exp_q.push_back(model_out(data_a, data_b, data_c));
      tick();
      check($sformatf("random_%0d", c), exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
